// File: rtl/anton_neopixel_sequencer_pkg.sv
// Shared definitions for the neopixel sequencer: the sequencer FSM encoding,
// the stream-datapath state values and the default sizing constants.
package anton_neopixel_sequencer_pkg;

   // Internal sequencer states.
   typedef enum logic [1:0] {
      SEQ_IDLE     = 2'd0,
      SEQ_TRANSMIT = 2'd1,
      SEQ_RESET    = 2'd2,
      SEQ_DONE     = 2'd3
   } seqState_t;

   // Values of the 'state' output consumed by the stream datapath.
   localparam logic STATE_TRANSMIT = 1'b1;
   localparam logic STATE_RESET    = 1'b0;

   // Last valid byte index of the pixel buffer (24-byte buffer).
   localparam int BUFFER_END_DEFAULT  = 23;
   // 400 slot clocks = 62.5 us at 6.4 MHz, above the 50 us latch time.
   localparam int RESET_DELAY_DEFAULT = 400;

endpackage

// File: rtl/anton_neopixel_bit_timer.sv
// Bit timer: walks the 8 pattern slots of each bit and the 24 bits of each
// pixel, and strobes pixelEnd on the final slot of the final bit.
module anton_neopixel_bit_timer (
   input  logic       clk,
   input  logic       rstn,
   input  logic       enable,
   input  logic       clear,
   output logic [4:0] pixelBitIndex,
   output logic [2:0] bitPatternIndex,
   output logic       pixelEnd
);

   // Last slot of the last bit of the current pixel.
   assign pixelEnd = enable && (bitPatternIndex == 3'd7) && (pixelBitIndex == 5'd23);

   // Slot/bit counters; clear wins over enable so an abort lands on index 0.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pixelBitIndex   <= 5'd0;
         bitPatternIndex <= 3'd0;
      end else if (clear) begin
         pixelBitIndex   <= 5'd0;
         bitPatternIndex <= 3'd0;
      end else if (enable) begin
         // NOTE: non-blocking assignments so both counters see pre-edge values.
         bitPatternIndex <= bitPatternIndex + 3'd1;
         if (bitPatternIndex == 3'd7) begin
            pixelBitIndex <= (pixelBitIndex == 5'd23) ? 5'd0 : pixelBitIndex + 5'd1;
         end
      end
   end

endmodule

// File: rtl/anton_neopixel_sequencer.sv
// Neopixel sequencer: drives the pixel/bit/slot indices and the stream state,
// serves the latch (reset) period after each frame and restarts in loop mode.
// Optional build macro ANTON_NEOPIXEL_FRAME_COUNTER_EN adds frameCount[15:0].
module anton_neopixel_sequencer
   import anton_neopixel_sequencer_pkg::*;
#(
   parameter  int BUFFER_END  = BUFFER_END_DEFAULT,
   parameter  int RESET_DELAY = RESET_DELAY_DEFAULT,
   localparam int BUFFER_BITS = $clog2(BUFFER_END + 1)
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   regCtrlRun,
   input  logic                   regCtrlLoop,
   input  logic                   regCtrl32bit,
   input  logic [BUFFER_BITS-1:0] regCtrlLimit,
   output logic                   state,
   output logic [BUFFER_BITS-1:0] pixelIndex,
   output logic [4:0]             pixelBitIndex,
   output logic [2:0]             bitPatternIndex,
   output logic                   streamBusy,
   output logic                   frameDone
`ifdef ANTON_NEOPIXEL_FRAME_COUNTER_EN
   ,
   output logic [15:0]            frameCount
`endif
);

   localparam int                     CNT_BITS = $clog2(RESET_DELAY + 1);
   localparam logic [CNT_BITS-1:0]    CNT_LAST = CNT_BITS'(RESET_DELAY - 1);
   localparam logic [BUFFER_BITS:0]   END_IDX  = (BUFFER_BITS + 1)'(BUFFER_END);

   seqState_t              seq;
   seqState_t              seqNext;
   logic                   mode32;
   logic [CNT_BITS-1:0]    resetCount;
   logic [CNT_BITS-1:0]    resetCountNext;
   logic                   resetLast;
   logic                   pixelEnd;
   logic                   lastPixel;
   logic [BUFFER_BITS-1:0] stride;

   assign stride    = mode32 ? BUFFER_BITS'(4) : BUFFER_BITS'(1);
   assign resetLast = (resetCount == CNT_LAST);

   anton_neopixel_bit_timer bitTimer (
      .clk             (clk),
      .rstn            (rstn),
      .enable          (seq == SEQ_TRANSMIT),
      .clear           (seqNext != SEQ_TRANSMIT),
      .pixelBitIndex   (pixelBitIndex),
      .bitPatternIndex (bitPatternIndex),
      .pixelEnd        (pixelEnd)
   );

   // Last-pixel test: limit reached (word-granular in 32-bit mode) or the
   // next stride would step past the end of the buffer.
   always_comb begin
      // NOTE: default first so no path through this block infers a latch.
      lastPixel = 1'b0;
      if (mode32) begin
         lastPixel = pixelIndex[BUFFER_BITS-1:2] >= regCtrlLimit[BUFFER_BITS-1:2];
      end else begin
         lastPixel = pixelIndex >= regCtrlLimit;
      end
      if (({1'b0, pixelIndex} + {1'b0, stride}) > END_IDX) begin
         lastPixel = 1'b1;
      end
   end

   // Next-state logic and the reset-period counter's next value.
   always_comb begin
      seqNext        = seq;
      resetCountNext = '0;
      case (seq)
         SEQ_IDLE: begin
            if (regCtrlRun) seqNext = SEQ_TRANSMIT;
         end
         SEQ_TRANSMIT: begin
            if (!regCtrlRun || (pixelEnd && lastPixel)) seqNext = SEQ_RESET;
         end
         SEQ_RESET: begin
            if (!resetLast) begin
               resetCountNext = resetCount + CNT_BITS'(1);
            end else if (regCtrlRun && regCtrlLoop) begin
               seqNext = SEQ_TRANSMIT;
            end else if (!regCtrlRun) begin
               seqNext = SEQ_IDLE;
            end else begin
               seqNext = SEQ_DONE;
            end
         end
         SEQ_DONE: begin
            if (!regCtrlRun) seqNext = SEQ_IDLE;
         end
         default: seqNext = SEQ_IDLE;
      endcase
   end

   // State, mode latch, reset counter, pixel index and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         seq        <= SEQ_IDLE;
         mode32     <= 1'b0;
         resetCount <= '0;
         pixelIndex <= '0;
         state      <= STATE_RESET;
         streamBusy <= 1'b0;
         frameDone  <= 1'b0;
      end else begin
         seq        <= seqNext;
         resetCount <= resetCountNext;
         if ((seqNext == SEQ_TRANSMIT) && (seq != SEQ_TRANSMIT)) begin
            mode32 <= regCtrl32bit;
         end
         if (seqNext != SEQ_TRANSMIT) begin
            pixelIndex <= '0;
         end else if (pixelEnd) begin
            pixelIndex <= pixelIndex + stride;
         end
         state      <= (seqNext == SEQ_TRANSMIT) ? STATE_TRANSMIT : STATE_RESET;
         streamBusy <= (seqNext == SEQ_TRANSMIT) || (seqNext == SEQ_RESET);
         frameDone  <= (seqNext == SEQ_RESET) && (resetCountNext == CNT_LAST);
      end
   end

`ifdef ANTON_NEOPIXEL_FRAME_COUNTER_EN
   // Frames completed since the sequencer last went idle; wraps at 16 bits.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         frameCount <= 16'd0;
      end else if ((seqNext == SEQ_IDLE) && ((seq == SEQ_DONE) || (seq == SEQ_RESET))) begin
         frameCount <= 16'd0;
      end else if (frameDone) begin
         frameCount <= frameCount + 16'd1;
      end
   end
`endif

endmodule
